vec_mem_sequencer: RTL and testbench

//  Parametrised successor to the MEM-stage address/input/output managers. Serialises one vector

---
 rtl/vms_pkg.sv | 28 ++
 rtl/vms_lane_buffer.sv | 36 +++
 rtl/vec_mem_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_vec_mem_sequencer.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vms_pkg.sv
// vms_pkg: shared types, default sizes and the lane address helper for the
// vector memory sequencer.
// Contents: vms_state_t (FSM states), default parameter values, IDX_W,
// lane_addr() (base + idx*stride; the caller truncates to its address width).
package vms_pkg;

    localparam int unsigned VMS_LANES  = 16;
    localparam int unsigned VMS_ELEM_W = 16;
    localparam int unsigned VMS_ADDR_W = 19;
    localparam int unsigned VMS_RD_W   = 5;
    localparam int unsigned IDX_W      = $clog2(VMS_LANES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        READ  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } vms_state_t;

    // 32-bit arithmetic; the caller truncates, so addresses wrap silently
    function automatic logic [31:0] lane_addr(input logic [31:0] base,
                                              input logic [31:0] idx,
                                              input logic [31:0] stride);
        lane_addr = base + idx * stride;
    endfunction

endpackage

// File: rtl/vms_lane_buffer.sv
// vms_lane_buffer: LANES x ELEM_W capture register for gathering load lanes.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   clr_i        synchronous clear of all lanes
//   wr_en_i      write one lane this cycle
//   wr_idx_i     lane index to write
//   wr_data_i    lane data
//   data_o       flat vector, lane i = bits [i*ELEM_W +: ELEM_W]
module vms_lane_buffer #(
    parameter int unsigned LANES  = 16,
    parameter int unsigned ELEM_W = 16,
    parameter int unsigned IDX_W  = $clog2(LANES)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    wr_en_i,
    input  logic [IDX_W-1:0]        wr_idx_i,
    input  logic [ELEM_W-1:0]       wr_data_i,
    output logic [LANES*ELEM_W-1:0] data_o
);

    logic [LANES*ELEM_W-1:0] lanes_q;

    // lane storage
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            lanes_q <= '0;
        end else if (wr_en_i) begin
            lanes_q[wr_idx_i*ELEM_W +: ELEM_W] <= wr_data_i;
        end
    end

    assign data_o = lanes_q;

endmodule

// File: rtl/vec_mem_sequencer.sv
// vec_mem_sequencer: serialises one vector load/store of LANES elements onto
// a single-element memory port, one element per cycle, and gathers load lanes
// into a full vector for write-back. Stalls the pipeline while busy.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/req_ready          request handshake (ready only in IDLE)
//   req_write, req_addr, req_rd  access type, base address, destination reg
//   req_wdata                    store vector
//   req_stride                   element stride (only with VMS_STRIDE_EN)
//   mem_addr, mem_we, mem_wdata  memory request, mem_rdata one cycle later
//   stall                        pipeline freeze, = ~req_ready
//   done, rsp_valid              end-of-access pulse, load response pulse
//   rsp_rd, rsp_data             load destination and gathered vector
// Build option: define VMS_STRIDE_EN for strided access; otherwise stride is 1.
module vec_mem_sequencer
    import vms_pkg::*;
#(
    parameter int unsigned LANES  = VMS_LANES,
    parameter int unsigned ELEM_W = VMS_ELEM_W,
    parameter int unsigned ADDR_W = VMS_ADDR_W,
    parameter int unsigned RD_W   = VMS_RD_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_W-1:0]       req_addr,
    input  logic [RD_W-1:0]         req_rd,
    input  logic [LANES*ELEM_W-1:0] req_wdata,
`ifdef VMS_STRIDE_EN
    input  logic [ADDR_W-1:0]       req_stride,
`endif
    output logic [ADDR_W-1:0]       mem_addr,
    output logic                    mem_we,
    output logic [ELEM_W-1:0]       mem_wdata,
    input  logic [ELEM_W-1:0]       mem_rdata,
    output logic                    stall,
    output logic                    done,
    output logic                    rsp_valid,
    output logic [RD_W-1:0]         rsp_rd,
    output logic [LANES*ELEM_W-1:0] rsp_data
);

    localparam int unsigned LIDX_W = $clog2(LANES);
    localparam int unsigned VEC_W  = LANES * ELEM_W;
    localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(LANES - 1);

    vms_state_t          state_q, state_d;
    logic [LIDX_W-1:0]   idx_q, idx_d, nxt_idx;
    logic [ADDR_W-1:0]   base_q, base_d, stride_q, stride_d, stride_in;
    logic [RD_W-1:0]     rd_q, rd_d;
    logic [VEC_W-1:0]    wdata_q, wdata_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_we_q, mem_we_d;
    logic [ELEM_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                done_q, done_d, rsp_valid_q, rsp_valid_d;
    logic                ready_q, stall_q;
    logic [VEC_W-1:0]    rsp_data_q, rsp_data_d;
    logic                cap_en, cap_clr;
    logic [LIDX_W-1:0]   cap_idx;
    logic [VEC_W-1:0]    lane_vec;

`ifdef VMS_STRIDE_EN
    assign stride_in = req_stride;
`else
    assign stride_in = ADDR_W'(1);
`endif

    assign nxt_idx = idx_q + LIDX_W'(1);

    // next state, address generation and lane capture control
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        base_d      = base_q;
        stride_d    = stride_q;
        rd_d        = rd_q;
        wdata_d     = wdata_q;
        mem_addr_d  = mem_addr_q;
        mem_we_d    = 1'b0;
        mem_wdata_d = mem_wdata_q;
        done_d      = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        cap_en      = 1'b0;
        cap_clr     = 1'b0;
        cap_idx     = LAST_IDX;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    base_d     = req_addr;
                    stride_d   = stride_in;
                    rd_d       = req_rd;
                    wdata_d    = req_wdata;
                    idx_d      = '0;
                    cap_clr    = 1'b1;
                    mem_addr_d = req_addr;
                    if (req_write) begin
                        state_d     = WRITE;
                        mem_we_d    = 1'b1;
                        mem_wdata_d = req_wdata[ELEM_W-1:0];
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    idx_d       = nxt_idx;
                    mem_addr_d  = ADDR_W'(lane_addr(32'(base_q), 32'(nxt_idx), 32'(stride_q)));
                    mem_we_d    = 1'b1;
                    mem_wdata_d = wdata_q[nxt_idx*ELEM_W +: ELEM_W];
                end
            end
            READ: begin
                // read data trails its address by one cycle
                cap_en  = (idx_q != '0);
                cap_idx = idx_q - LIDX_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d      = nxt_idx;
                    mem_addr_d = ADDR_W'(lane_addr(32'(base_q), 32'(nxt_idx), 32'(stride_q)));
                end
            end
            DRAIN: begin
                cap_en      = 1'b1;
                cap_idx     = LAST_IDX;
                state_d     = DONE;
                done_d      = 1'b1;
                rsp_valid_d = 1'b1;
                // top lane of the buffer is still clear here, so OR-in the final element
                rsp_data_d  = lane_vec | {mem_rdata, {(VEC_W-ELEM_W){1'b0}}};
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            base_q      <= '0;
            stride_q    <= '0;
            rd_q        <= '0;
            wdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            ready_q     <= 1'b1;
            stall_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            base_q      <= base_d;
            stride_q    <= stride_d;
            rd_q        <= rd_d;
            wdata_q     <= wdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
            done_q      <= done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            ready_q     <= (state_d == IDLE);
            stall_q     <= (state_d != IDLE);
        end
    end

    vms_lane_buffer #(
        .LANES  (LANES),
        .ELEM_W (ELEM_W),
        .IDX_W  (LIDX_W)
    ) u_lane_buffer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (cap_clr),
        .wr_en_i   (cap_en),
        .wr_idx_i  (cap_idx),
        .wr_data_i (mem_rdata),
        .data_o    (lane_vec)
    );

    assign req_ready = ready_q;
    assign stall     = stall_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign done      = done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rd    = rd_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: directed table, corner-case
// sequences (mid-access reset, back-to-back) and randomized accesses against
// an arithmetic reference model. Memory returns mem[a] = a[15:0].
module tb_vec_mem_sequencer;

    localparam int LANES  = 16;
    localparam int ELEM_W = 16;
    localparam int ADDR_W = 19;
    localparam int RD_W   = 5;
    localparam int VW     = LANES * ELEM_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              req_valid, req_ready, req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [RD_W-1:0]   req_rd;
    logic [VW-1:0]     req_wdata;
`ifdef VMS_STRIDE_EN
    logic [ADDR_W-1:0] req_stride;
`endif
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [ELEM_W-1:0] mem_wdata;
    logic [ELEM_W-1:0] mem_rdata = '0;
    logic              stall, done, rsp_valid;
    logic [RD_W-1:0]   rsp_rd;
    logic [VW-1:0]     rsp_data;

    int n_pass  = 0;
    int n_total = 0;
    logic [VW-1:0] exp_rsp = '0;

    vec_mem_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_rd    (req_rd),
        .req_wdata (req_wdata),
`ifdef VMS_STRIDE_EN
        .req_stride(req_stride),
`endif
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall),
        .done      (done),
        .rsp_valid (rsp_valid),
        .rsp_rd    (rsp_rd),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    // synchronous memory: data for an address appears one cycle later
    always @(posedge clk) mem_rdata <= mem_addr[ELEM_W-1:0];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic void chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endfunction

    function automatic logic [ADDR_W-1:0] model_addr(input logic [ADDR_W-1:0] b, input int i,
                                                      input logic [ADDR_W-1:0] s);
        longint unsigned t;
        t = (longint'(b) + longint'(i) * longint'(s)) % (longint'(1) << ADDR_W);
        return ADDR_W'(t);
    endfunction

    function automatic logic [VW-1:0] model_load(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s);
        logic [VW-1:0] v;
        logic [ADDR_W-1:0] ad;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            ad = model_addr(b, i, s);
            v[i*ELEM_W +: ELEM_W] = ad[ELEM_W-1:0];
        end
        return v;
    endfunction

    function automatic logic [VW-1:0] make_wdata(input logic [ELEM_W-1:0] wbase);
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*ELEM_W +: ELEM_W] = wbase + ELEM_W'(i);
        return v;
    endfunction

    function automatic logic [VW-1:0] rand_vec();
        logic [VW-1:0] v;
        for (int i = 0; i < VW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic drive_req(input bit w, input logic [ADDR_W-1:0] a, input logic [RD_W-1:0] rd,
                             input logic [VW-1:0] wd, input logic [ADDR_W-1:0] s);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_rd    = rd;
        req_wdata = wd;
`ifdef VMS_STRIDE_EN
        req_stride = s;
`endif
    endtask

    // one complete access, checked cycle by cycle against the model
    task automatic run_access(input bit w, input logic [ADDR_W-1:0] a, input logic [RD_W-1:0] rd,
                              input logic [VW-1:0] wd, input logic [ADDR_W-1:0] s,
                              input logic [ADDR_W-1:0] exp_last, input int done_k);
        int guard;
        logic [ADDR_W-1:0] ea;
        guard = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before_accept", VW'(req_ready), VW'(1));
        drive_req(w, a, rd, wd, s);
        for (int k = 1; k <= done_k + 1; k++) begin
            @(negedge clk);
            if (k == 1) begin
                // later input changes must be ignored
                req_valid = 1'b0;
                req_addr  = ADDR_W'($urandom);
                req_rd    = RD_W'($urandom);
                req_write = 1'($urandom);
                req_wdata = rand_vec();
`ifdef VMS_STRIDE_EN
                req_stride = ADDR_W'($urandom);
`endif
            end
            if (k <= LANES) begin
                ea = model_addr(a, k - 1, s);
                chk("lane_addr", VW'(mem_addr), VW'(ea));
                chk("lane_we", VW'(mem_we), VW'(w));
                if (w) chk("lane_wdata", VW'(mem_wdata), VW'(wd[(k-1)*ELEM_W +: ELEM_W]));
                chk("stall_busy", VW'(stall), VW'(1));
                chk("ready_busy", VW'(req_ready), VW'(0));
            end else if (k <= done_k) begin
                chk("we_after_lanes", VW'(mem_we), VW'(0));
                chk("stall_tail", VW'(stall), VW'(1));
            end
            if (k == LANES) chk("last_addr", VW'(mem_addr), VW'(exp_last));
            if (k <= done_k) begin
                chk("done_pulse", VW'(done), VW'(k == done_k));
                chk("rsp_valid_pulse", VW'(rsp_valid), VW'(!w && k == done_k));
            end
            if (k == done_k) begin
                if (!w) begin
                    exp_rsp = model_load(a, s);
                    chk("rsp_rd", VW'(rsp_rd), VW'(rd));
                end
                chk("rsp_data", rsp_data, exp_rsp);
            end
            if (k == done_k + 1) begin
                chk("idle_ready", VW'(req_ready), VW'(1));
                chk("idle_stall", VW'(stall), VW'(0));
                chk("idle_done", VW'(done), VW'(0));
                chk("idle_we", VW'(mem_we), VW'(0));
            end
        end
    endtask

    typedef struct {
        bit                w;
        logic [ADDR_W-1:0] addr;
        logic [RD_W-1:0]   rd;
        logic [ELEM_W-1:0] wbase;
        logic [ADDR_W-1:0] stride;
        logic [ADDR_W-1:0] exp_last;
        int                exp_done_k;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int k, guard;
        bit seen;
        logic [ADDR_W-1:0] ra, rs, rl;
        logic [VW-1:0] wd;
        bit rw;

        tbl[0] = '{1'b1, 19'h00100, 5'd0,  16'hA000, 19'd1, 19'h0010F, 17};
        tbl[1] = '{1'b0, 19'h00200, 5'd7,  16'h0000, 19'd1, 19'h0020F, 18};
        tbl[2] = '{1'b0, 19'h7FFFE, 5'd3,  16'h0000, 19'd1, 19'h0000D, 18};
        tbl[3] = '{1'b1, 19'h7FFF8, 5'd12, 16'h5550, 19'd1, 19'h00007, 17};
        tbl[4] = '{1'b0, 19'h00000, 5'd31, 16'h0000, 19'd1, 19'h0000F, 18};

        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_rd = '0; req_wdata = '0;
`ifdef VMS_STRIDE_EN
        req_stride = '0;
`endif
        repeat (2) @(negedge clk);
        chk("reset_ready", VW'(req_ready), VW'(1));
        chk("reset_stall", VW'(stall), VW'(0));
        chk("reset_mem_addr", VW'(mem_addr), VW'(0));
        chk("reset_mem_we", VW'(mem_we), VW'(0));
        chk("reset_mem_wdata", VW'(mem_wdata), VW'(0));
        chk("reset_done", VW'(done), VW'(0));
        chk("reset_rsp_valid", VW'(rsp_valid), VW'(0));
        chk("reset_rsp_rd", VW'(rsp_rd), VW'(0));
        chk("reset_rsp_data", rsp_data, '0);
        rst = 1'b0;

        for (int t = 0; t < 5; t++)
            run_access(tbl[t].w, tbl[t].addr, tbl[t].rd, make_wdata(tbl[t].wbase), tbl[t].stride,
                       tbl[t].exp_last, tbl[t].exp_done_k);

        // reset in the middle of a load at lane 5
        @(negedge clk);
        drive_req(1'b0, 19'h00500, 5'd9, '0, 19'd1);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_pre_idx5_addr", VW'(mem_addr), VW'(19'h00505));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", VW'(req_ready), VW'(1));
        chk("rst_mid_stall", VW'(stall), VW'(0));
        chk("rst_mid_we", VW'(mem_we), VW'(0));
        chk("rst_mid_addr", VW'(mem_addr), VW'(0));
        chk("rst_mid_rsp_data", rsp_data, '0);
        chk("rst_mid_rsp_rd", VW'(rsp_rd), VW'(0));
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done || rsp_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("rst_mid_no_pulse", VW'(seen), VW'(0));
        exp_rsp = '0;

        // back-to-back: req_valid held high through DONE
        @(negedge clk);
        drive_req(1'b0, 19'h00300, 5'd2, '0, 19'd1);
        @(negedge clk);
        wd = make_wdata(16'hC000);
        drive_req(1'b1, 19'h00600, 5'd4, wd, 19'd1);
        k = 1;
        seen = 1'b1;
        while (done !== 1'b1 && k < 40) begin
            if (stall !== 1'b1) seen = 1'b0;
            @(negedge clk);
            k++;
        end
        chk("b2b_stall_held", VW'(seen), VW'(1));
        chk("b2b_done_cycle", VW'(k), VW'(18));
        chk("b2b_no_accept_in_done", VW'(req_ready), VW'(0));
        exp_rsp = model_load(19'h00300, 19'd1);
        chk("b2b_load_data", rsp_data, exp_rsp);
        @(negedge clk);
        chk("b2b_idle_bubble", VW'(req_ready), VW'(1));
        @(negedge clk);
        req_valid = 1'b0;
        chk("b2b_second_accept", VW'(req_ready), VW'(0));
        chk("b2b_second_we", VW'(mem_we), VW'(1));
        chk("b2b_second_addr", VW'(mem_addr), VW'(19'h00600));
        chk("b2b_second_wdata", VW'(mem_wdata), VW'(16'hC000));
        k = 1;
        while (done !== 1'b1 && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("b2b_store_done_cycle", VW'(k), VW'(17));
        chk("b2b_rsp_held", rsp_data, exp_rsp);

`ifdef VMS_STRIDE_EN
        run_access(1'b0, 19'h00040, 5'd5, '0, 19'd4, 19'h0007C, 18);
        run_access(1'b0, 19'h00040, 5'd6, '0, 19'd0, 19'h00040, 18);
        run_access(1'b1, 19'h00010, 5'd1, make_wdata(16'h1230), 19'h7FFFF, 19'h00001, 17);
`endif

        // randomized accesses
        for (int r = 0; r < 25; r++) begin
            rw = 1'($urandom);
            ra = ADDR_W'($urandom);
`ifdef VMS_STRIDE_EN
            rs = ($urandom_range(0, 4) == 0) ? '0 : ADDR_W'($urandom_range(0, 300));
`else
            rs = ADDR_W'(1);
`endif
            rl = model_addr(ra, LANES - 1, rs);
            guard = $urandom_range(0, 3);
            repeat (guard) @(negedge clk);
            run_access(rw, ra, RD_W'($urandom), rand_vec(), rs, rl, rw ? LANES + 1 : LANES + 2);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
